// File: rtl/uart_prog_loader_ctrl.sv
// uart_prog_loader_ctrl: loads little-endian program words from the UART into memory and
// holds the core in reset until the end-of-program marker word arrives.
module uart_prog_loader_ctrl #(
   parameter int unsigned       ADDR_W       = 14,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter logic [31:0]       END_WORD     = 32'h0000_0FFF,
   parameter logic [23:0]       TIMEOUT_CLKS = 24'd1_000_000,
   parameter logic [15:0]       DEFAULT_CPB  = 16'd868
) (
   input  logic              i_Clock,
   input  logic              rst_ni,
   input  logic              i_prog_en,
   input  logic              i_cpb_wr,
   input  logic [15:0]       i_cpb_cfg,
   output logic [15:0]       o_clks_per_bit,
   input  logic              i_rx_dv,
   input  logic [7:0]        i_rx_byte,
   output logic              o_mem_req,
   input  logic              i_mem_gnt,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [ADDR_W:0]   o_word_cnt,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_core_rst_n,
   output logic              o_ovf_err,
   output logic              o_to_err
);
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   state_e            state_q, state_d;
   logic [15:0]       cpb_q, cpb_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              crst_q, crst_d;
   logic              ovf_q, ovf_d;
   logic              to_q, to_d;
   logic              hold_v_q, hold_v_d;
   logic [7:0]        hold_q, hold_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [23:0]       word_q, word_d;
   logic [23:0]       tcnt_q, tcnt_d;
   logic              src_v;
   logic [7:0]        src_b;
   logic [31:0]       full_w;

   always_ff @(posedge i_Clock or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cpb_q    <= DEFAULT_CPB;
         req_q    <= 1'b0;
         addr_q   <= BASE_ADDR;
         wdata_q  <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         crst_q   <= 1'b0;
         ovf_q    <= 1'b0;
         to_q     <= 1'b0;
         hold_v_q <= 1'b0;
         hold_q   <= '0;
         bcnt_q   <= '0;
         word_q   <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         cpb_q    <= cpb_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         crst_q   <= crst_d;
         ovf_q    <= ovf_d;
         to_q     <= to_d;
         hold_v_q <= hold_v_d;
         hold_q   <= hold_d;
         bcnt_q   <= bcnt_d;
         word_q   <= word_d;
         tcnt_q   <= tcnt_d;
      end
   end

   // A held byte is always older than a byte arriving now, so it is consumed first.
   assign src_v  = hold_v_q | i_rx_dv;
   assign src_b  = hold_v_q ? hold_q : i_rx_byte;
   assign full_w = {src_b, word_q};

   always_comb begin
      state_d  = state_q;
      cpb_d    = cpb_q;
      req_d    = req_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      crst_d   = crst_q;
      ovf_d    = ovf_q;
      to_d     = to_q;
      hold_v_d = hold_v_q;
      hold_d   = hold_q;
      bcnt_d   = bcnt_q;
      word_d   = word_q;
      tcnt_d   = tcnt_q;
      if ((state_q == IDLE || state_q == DONE) && i_cpb_wr && i_cpb_cfg >= 16'd2)
         cpb_d = i_cpb_cfg;
      unique case (state_q)
         IDLE: if (i_prog_en) begin
            state_d  = COLLECT;
            bcnt_d   = '0;
            tcnt_d   = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            to_d     = 1'b0;
            hold_v_d = 1'b0;
            addr_d   = BASE_ADDR;
            crst_d   = 1'b0;
         end
         COLLECT: if (!i_prog_en) begin
            state_d = IDLE;
            bcnt_d  = '0;
            tcnt_d  = '0;
         end else if (src_v) begin
            tcnt_d   = '0;
            hold_v_d = hold_v_q & i_rx_dv;
            hold_d   = hold_v_q ? i_rx_byte : hold_q;
            word_d   = {src_b, word_q[23:8]};
            bcnt_d   = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
               if (full_w == END_WORD) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  crst_d  = 1'b1;
               end else begin
                  state_d = WRITE;
                  wdata_d = full_w;
                  req_d   = 1'b1;
               end
            end
         end else if (bcnt_q != 2'd0) begin
            tcnt_d = tcnt_q + 24'd1;
            if (tcnt_d == TIMEOUT_CLKS) begin
               bcnt_d = '0;
               tcnt_d = '0;
               to_d   = 1'b1;
            end
         end
         WRITE: begin
            if (i_rx_dv) begin
               ovf_d    = ovf_q | hold_v_q;
               hold_v_d = 1'b1;
               hold_d   = hold_v_q ? hold_q : i_rx_byte;
            end
            if (req_q && i_mem_gnt) begin
               req_d   = 1'b0;
               addr_d  = addr_q + ADDR_ONE;
               cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_ONE;
               state_d = i_prog_en ? COLLECT : IDLE;
            end
         end
         DONE: state_d = i_prog_en ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_clks_per_bit = cpb_q;
   assign o_mem_req      = req_q;
   assign o_mem_addr     = addr_q;
   assign o_mem_wdata    = wdata_q;
   assign o_word_cnt     = cnt_q;
   assign o_busy         = (state_q == COLLECT) || (state_q == WRITE);
   assign o_done         = done_q;
   assign o_core_rst_n   = crst_q;
   assign o_ovf_err      = ovf_q;
   assign o_to_err       = to_q;
endmodule

// File: tb/tb_uart_prog_loader_ctrl.sv
// tb_uart_prog_loader_ctrl: directed program loads checked against a byte-stream word model.
module tb_uart_prog_loader_ctrl;
   logic        i_Clock = 1'b0;
   logic        rst_ni = 1'b0;
   logic        i_prog_en = 1'b0;
   logic        i_cpb_wr = 1'b0;
   logic [15:0] i_cpb_cfg = '0;
   logic [15:0] o_clks_per_bit;
   logic        i_rx_dv = 1'b0;
   logic [7:0]  i_rx_byte = '0;
   logic        o_mem_req;
   logic        i_mem_gnt = 1'b0;
   logic [13:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [14:0] o_word_cnt;
   logic        o_busy, o_done, o_core_rst_n, o_ovf_err, o_to_err;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cpb = 16'd868;
   logic [7:0]  mq[$];
   logic [13:0] qa[$];
   logic [31:0] qd[$];
   logic [13:0] exp_addr = '0;
   logic        prev_hold = 1'b0;
   logic [13:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   uart_prog_loader_ctrl #(.TIMEOUT_CLKS(24'd100)) dut (
      .i_Clock(i_Clock), .rst_ni(rst_ni), .i_prog_en(i_prog_en), .i_cpb_wr(i_cpb_wr),
      .i_cpb_cfg(i_cpb_cfg), .o_clks_per_bit(o_clks_per_bit), .i_rx_dv(i_rx_dv),
      .i_rx_byte(i_rx_byte), .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_word_cnt(o_word_cnt),
      .o_busy(o_busy), .o_done(o_done), .o_core_rst_n(o_core_rst_n),
      .o_ovf_err(o_ovf_err), .o_to_err(o_to_err));

   always #5 i_Clock = ~i_Clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_Clock);
      #1;
   endtask

   // Model: every kept byte joins the stream; each 4 bytes form a little-endian word.
   task automatic send_byte(input logic [7:0] b, input bit keep);
      logic [31:0] w;
      i_rx_dv = 1'b1;
      i_rx_byte = b;
      cyc(1);
      i_rx_dv = 1'b0;
      if (keep) begin
         mq.push_back(b);
         if (mq.size() == 4) begin
            w = 32'(mq[0]) + (32'(mq[1]) << 8) + (32'(mq[2]) << 16) + (32'(mq[3]) << 24);
            mq.delete();
            if (w != 32'h0000_0FFF) begin
               qa.push_back(exp_addr);
               qd.push_back(w);
               exp_addr = exp_addr + 14'd1;
            end
         end
      end
   endtask

   task automatic model_start();
      mq.delete();
      exp_addr = '0;
   endtask

   always @(negedge i_Clock) begin
      if (!rst_ni) prev_hold = 1'b0;
      else begin
         chk("cpb", 32'(o_clks_per_bit), 32'(exp_cpb));
         if (o_mem_req) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got addr %h data %h expected no request", o_mem_addr, o_mem_wdata);
            end else begin
               chk("wr_addr", 32'(o_mem_addr), 32'(qa[0]));
               chk("wr_data", o_mem_wdata, qd[0]);
               if (i_mem_gnt) begin
                  void'(qa.pop_front());
                  void'(qd.pop_front());
               end
            end
         end
         if (prev_hold) begin
            chk("req_stable", 32'(o_mem_req), 32'd1);
            chk("addr_stable", 32'(o_mem_addr), 32'(prev_addr));
            chk("data_stable", o_mem_wdata, prev_data);
         end
         prev_hold = o_mem_req && !i_mem_gnt;
         prev_addr = o_mem_addr;
         prev_data = o_mem_wdata;
      end
   end

   initial begin
      cyc(3);
      chk("rst_cpb", 32'(o_clks_per_bit), 32'd868);
      chk("rst_crst", 32'(o_core_rst_n), 32'd0);
      chk("rst_req", 32'(o_mem_req), 32'd0);
      chk("rst_flags", {o_busy, o_done, o_ovf_err, o_to_err}, 32'd0);
      chk("rst_addr_cnt_data", 32'(o_mem_addr) + 32'(o_word_cnt) + o_mem_wdata, 32'd0);
      rst_ni = 1'b1;
      cyc(2);
      i_cpb_wr = 1'b1; i_cpb_cfg = 16'h0010;
      cyc(1);
      exp_cpb = 16'd16;
      chk("cpb_16", 32'(o_clks_per_bit), 32'd16);
      i_cpb_cfg = 16'h0001;
      cyc(1);
      i_cpb_wr = 1'b0;
      chk("cpb_1_ignored", 32'(o_clks_per_bit), 32'd16);
      i_mem_gnt = 1'b1;
      i_prog_en = 1'b1;
      model_start();
      cyc(1);
      chk("load_busy", 32'(o_busy), 32'd1);
      send_byte(8'h78, 1); cyc(1);
      send_byte(8'h56, 1); cyc(1);
      send_byte(8'h34, 1); cyc(1);
      chk("req_before_4th", 32'(o_mem_req), 32'd0);
      send_byte(8'h12, 1);
      chk("req_after_4th", 32'(o_mem_req), 32'd1);
      chk("w0_addr", 32'(o_mem_addr), 32'd0);
      chk("w0_data", o_mem_wdata, 32'h1234_5678);
      cyc(1);
      chk("w0_req_drop", 32'(o_mem_req), 32'd0);
      chk("w0_cnt", 32'(o_word_cnt), 32'd1);
      send_byte(8'hFF, 1); cyc(1);
      send_byte(8'h0F, 1); cyc(1);
      send_byte(8'h00, 1); cyc(1);
      chk("crst_before_end", 32'(o_core_rst_n), 32'd0);
      send_byte(8'h00, 1);
      chk("done", 32'(o_done), 32'd1);
      chk("done_crst", 32'(o_core_rst_n), 32'd1);
      chk("done_busy", 32'(o_busy), 32'd0);
      send_byte(8'h55, 0);
      cyc(2);
      chk("done_cnt", 32'(o_word_cnt), 32'd1);
      i_prog_en = 1'b0;
      cyc(2);
      chk("idle_keeps_done", {o_done, o_core_rst_n}, 32'd3);
      i_mem_gnt = 1'b0;
      i_prog_en = 1'b1;
      model_start();
      cyc(1);
      chk("restart", {o_done, o_core_rst_n, o_busy}, 32'd1);
      chk("restart_cnt", 32'(o_word_cnt), 32'd0);
      send_byte(8'h11, 1); cyc(1);
      send_byte(8'h22, 1); cyc(1);
      send_byte(8'h33, 1); cyc(1);
      send_byte(8'h44, 1);
      chk("w1_data", o_mem_wdata, 32'h4433_2211);
      cyc(5);
      send_byte(8'hAA, 1);
      chk("ovf_after_first", 32'(o_ovf_err), 32'd0);
      cyc(10);
      send_byte(8'hBB, 0);
      chk("ovf_set", 32'(o_ovf_err), 32'd1);
      cyc(23);
      chk("req_held", 32'(o_mem_req), 32'd1);
      i_mem_gnt = 1'b1;
      cyc(1);
      i_mem_gnt = 1'b0;
      chk("gnt_addr", 32'(o_mem_addr), 32'd1);
      chk("gnt_cnt", 32'(o_word_cnt), 32'd1);
      cyc(2);
      send_byte(8'hCC, 1); cyc(1);
      send_byte(8'hDD, 1); cyc(1);
      send_byte(8'hEE, 1);
      chk("held_byte0", o_mem_wdata, 32'hEEDD_CCAA);
      i_mem_gnt = 1'b1;
      cyc(1);
      chk("cnt2", 32'(o_word_cnt), 32'd2);
      send_byte(8'h01, 1); cyc(1);
      send_byte(8'h02, 1);
      cyc(99);
      chk("to_early", 32'(o_to_err), 32'd0);
      cyc(1);
      chk("to_set", 32'(o_to_err), 32'd1);
      mq.delete();
      send_byte(8'h05, 1); cyc(1);
      send_byte(8'h06, 1); cyc(1);
      send_byte(8'h07, 1); cyc(1);
      send_byte(8'h08, 1);
      chk("to_word_addr", 32'(o_mem_addr), 32'd2);
      chk("to_word_data", o_mem_wdata, 32'h0807_0605);
      cyc(1);
      chk("cnt3", 32'(o_word_cnt), 32'd3);
      i_cpb_wr = 1'b1; i_cpb_cfg = 16'h0020;
      cyc(1);
      i_cpb_wr = 1'b0;
      chk("cpb_collect_ignored", 32'(o_clks_per_bit), 32'd16);
      i_mem_gnt = 1'b0;
      send_byte(8'h9A, 1); cyc(1);
      send_byte(8'hBC, 1); cyc(1);
      send_byte(8'hDE, 1); cyc(1);
      send_byte(8'hF0, 1);
      chk("pre_rst_req", 32'(o_mem_req), 32'd1);
      rst_ni = 1'b0;
      exp_cpb = 16'd868;
      model_start();
      qa.delete();
      qd.delete();
      #1;
      chk("arst_req", 32'(o_mem_req), 32'd0);
      chk("arst_cpb", 32'(o_clks_per_bit), 32'd868);
      chk("arst_flags", {o_busy, o_done, o_core_rst_n, o_ovf_err, o_to_err}, 32'd0);
      chk("arst_addr_cnt_data", 32'(o_mem_addr) + 32'(o_word_cnt) + o_mem_wdata, 32'd0);
      cyc(2);
      rst_ni = 1'b1;
      cyc(1);
      chk("post_rst_busy", 32'(o_busy), 32'd1);
      send_byte(8'h31, 1); cyc(1);
      send_byte(8'h32, 1);
      i_prog_en = 1'b0;
      cyc(1);
      mq.delete();
      chk("abort_idle", {o_busy, o_core_rst_n, o_mem_req}, 32'd0);
      cyc(3);
      chk("writes_drained", 32'(qa.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
